// File: rtl/io_stager_pkg.sv
// Shared types and elaboration-time helpers for io_stager.
package io_stager_pkg;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} ser_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width that stays at least 1 bit for degenerate counts.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int wr_addr_w(input int x_in, input int w_words, input int lanes);
    return cnt_w(max2(ceil_div(x_in, lanes), ceil_div(w_words, lanes)));
  endfunction

endpackage

// File: rtl/io_stager_ser.sv
// Result serializer: captures a result vector and streams it out in OUT_LANES-word beats.
// IO_STAGER_DBUF_EN adds a shadow buffer so a second result can queue behind the active one.
module io_stager_ser
  import io_stager_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int X_IN       = 768,
  parameter int OUT_LANES  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            res_valid,
  input  logic [X_IN*DATA_WIDTH-1:0]      res_data,
  output logic                            res_ack,
  output logic                            out_valid,
  output logic [OUT_LANES*DATA_WIDTH-1:0] out_data,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic                            busy
);

  localparam int O_BEATS = ceil_div(X_IN, OUT_LANES);
  localparam int BEAT_W  = cnt_w(O_BEATS);
  localparam int PAD_W   = O_BEATS * OUT_LANES * DATA_WIDTH;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(O_BEATS - 1);

  typedef logic [O_BEATS-1:0][OUT_LANES*DATA_WIDTH-1:0] obuf_t;

  // Zero-extension makes the unused lanes of a partial final beat read as 0.
  obuf_t res_pad;
  assign res_pad = PAD_W'(res_data);

  obuf_t                buf_q;
  ser_state_e           state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 ack_q;
  logic                 cap_main;

`ifdef IO_STAGER_DBUF_EN
  obuf_t                shad_q;
  logic                 shad_full_q;
  logic                 cap_shad, load_shad;
`endif

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    cap_main = 1'b0;
`ifdef IO_STAGER_DBUF_EN
    cap_shad  = 1'b0;
    load_shad = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (res_valid) begin
          cap_main = 1'b1;
          state_d  = STREAM;
          beat_d   = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
`ifdef IO_STAGER_DBUF_EN
            if (shad_full_q) load_shad = 1'b1;
            else             state_d   = IDLE;
`else
            state_d = IDLE;
`endif
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
`ifdef IO_STAGER_DBUF_EN
        // No shadow capture on the edge the stream finishes; it retries from IDLE.
        if (res_valid && !shad_full_q && !(out_ready && beat_q == LAST_BEAT))
          cap_shad = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      ack_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
`ifdef IO_STAGER_DBUF_EN
      ack_q   <= cap_main | cap_shad;
      if (cap_main)       buf_q <= res_pad;
      else if (load_shad) buf_q <= shad_q;
`else
      ack_q   <= cap_main;
      if (cap_main) buf_q <= res_pad;
`endif
    end
  end

`ifdef IO_STAGER_DBUF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shad_q      <= '0;
      shad_full_q <= 1'b0;
    end else if (cap_shad) begin
      shad_q      <= res_pad;
      shad_full_q <= 1'b1;
    end else if (load_shad) begin
      shad_full_q <= 1'b0;
    end
  end
`endif

  assign res_ack   = ack_q;
  assign out_valid = (state_q == STREAM);
  assign out_last  = out_valid && (beat_q == LAST_BEAT);
  assign out_data  = out_valid ? buf_q[beat_q] : '0;
`ifdef IO_STAGER_DBUF_EN
  assign busy      = out_valid | shad_full_q;
`else
  assign busy      = out_valid;
`endif

endmodule

// File: rtl/io_stager.sv
// Accelerator I/O staging: masked multi-lane X/W loader plus result serializer.
// Define IO_STAGER_DBUF_EN to double-buffer results in the serializer.
module io_stager
  import io_stager_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  parameter  int X_IN       = 768,
  parameter  int W_WORDS    = 5625,
  parameter  int LANES      = 8,
  parameter  int OUT_LANES  = 4,
  localparam int WR_ADDR_W  = wr_addr_w(X_IN, W_WORDS, LANES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_valid,
  input  logic                            wr_sel,
  input  logic [WR_ADDR_W-1:0]            wr_addr,
  input  logic [LANES*DATA_WIDTH-1:0]     wr_data,
  input  logic [LANES-1:0]                wr_mask,
  output logic [X_IN*DATA_WIDTH-1:0]      x_out,
  output logic [W_WORDS*DATA_WIDTH-1:0]   w_out,
  input  logic                            res_valid,
  input  logic [X_IN*DATA_WIDTH-1:0]      res_data,
  output logic                            res_ack,
  output logic                            out_valid,
  output logic [OUT_LANES*DATA_WIDTH-1:0] out_data,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic                            busy
);

  logic [X_IN-1:0][DATA_WIDTH-1:0]    x_q;
  logic [W_WORDS-1:0][DATA_WIDTH-1:0] w_q;

  // Each word decodes its own (beat, lane); out-of-range beats and lanes match nothing.
  for (genvar j = 0; j < X_IN; j++) begin : g_x
    logic [DATA_WIDTH-1:0] word_q;
    logic                  hit;
    assign hit = wr_valid & wr_sel & wr_mask[j % LANES] &
                 (wr_addr == WR_ADDR_W'(j / LANES));
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)     word_q <= '0;
      else if (hit) word_q <= wr_data[(j % LANES)*DATA_WIDTH +: DATA_WIDTH];
    end
    assign x_q[j] = word_q;
  end

  for (genvar j = 0; j < W_WORDS; j++) begin : g_w
    logic [DATA_WIDTH-1:0] word_q;
    logic                  hit;
    assign hit = wr_valid & ~wr_sel & wr_mask[j % LANES] &
                 (wr_addr == WR_ADDR_W'(j / LANES));
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)     word_q <= '0;
      else if (hit) word_q <= wr_data[(j % LANES)*DATA_WIDTH +: DATA_WIDTH];
    end
    assign w_q[j] = word_q;
  end

  assign x_out = x_q;
  assign w_out = w_q;

  io_stager_ser #(
    .DATA_WIDTH (DATA_WIDTH),
    .X_IN       (X_IN),
    .OUT_LANES  (OUT_LANES)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ack   (res_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

endmodule

// File: tb/tb_io_stager.sv
// Directed bench for io_stager: table-driven write vectors plus serializer sequences.
module tb_io_stager;
  localparam int DW = 4, XI = 768, WW = 5625, LN = 8, OL = 4, AW = 10, OB = 192;

  logic              clk = 1'b0, rst = 1'b0;
  logic              wr_valid = 1'b0, wr_sel = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [LN*DW-1:0]  wr_data = '0;
  logic [LN-1:0]     wr_mask = '0;
  logic [XI*DW-1:0]  x_out;
  logic [WW*DW-1:0]  w_out;
  logic              res_valid = 1'b0;
  logic [XI*DW-1:0]  res_data = '0;
  logic              res_ack, out_valid, out_last, busy;
  logic [OL*DW-1:0]  out_data;
  logic              out_ready = 1'b0;

  int nvec = 0, nerr = 0;
  logic [3:0] xm [XI];
  logic [3:0] wm [WW];

  io_stager dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .x_out(x_out), .w_out(w_out),
    .res_valid(res_valid), .res_data(res_data), .res_ack(res_ack),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic vld; logic sel; int addr; logic [31:0] data; logic [7:0] mask;
    logic c0x; int c0w; logic [3:0] c0e;
    logic c1x; int c1w; logic [3:0] c1e;
  } wvec_t;
  wvec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] pat(input int r, input int j);
    return 4'((j + 5 * r) % 16);
  endfunction

  task automatic load_res(input int r);
    for (int j = 0; j < XI; j++) res_data[j*DW +: DW] = pat(r, j);
  endtask

  task automatic check_image(input string nm);
    int bad = 0;
    for (int j = 0; j < XI; j++) if (x_out[j*DW +: DW] !== xm[j]) bad++;
    for (int j = 0; j < WW; j++) if (w_out[j*DW +: DW] !== wm[j]) bad++;
    chk(nm, 64'(bad), 64'd0);
  endtask

  task automatic apply_write(input wvec_t t);
    @(negedge clk);
    wr_valid = t.vld; wr_sel = t.sel; wr_addr = AW'(t.addr);
    wr_data = t.data; wr_mask = t.mask;
    if (t.vld) begin
      for (int l = 0; l < LN; l++) begin
        int w;
        w = t.addr * LN + l;
        if (t.mask[l]) begin
          if (t.sel) begin
            if (t.addr < 96 && w < XI) xm[w] = t.data[l*DW +: DW];
          end else if (t.addr < 704 && w < WW) wm[w] = t.data[l*DW +: DW];
        end
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Acts as ff_block (hold res_valid until acked) and as the output sink.
  task automatic stream(input bit toggle, input int inject_at, input int stop_at);
    int beats = 0, acks = 0, lasts = 0, cyc = 0, hold = 0, nres, total, r, bb;
    bit injected = 0, started = 0;
    logic [OL*DW-1:0] exp;
`ifdef IO_STAGER_DBUF_EN
    nres = (inject_at >= 0) ? 2 : 1;
`else
    nres = 1;
`endif
    total = nres * OB;
    load_res(0);
    res_valid = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (res_ack) begin
        acks++;
        res_valid = 1'b0;
        if (!started) chk("first_lat_valid", 64'(out_valid), 64'd1);
      end
      if (out_valid) begin
        started = 1;
        r = beats / OB; bb = beats % OB;
        for (int i = 0; i < OL; i++) exp[i*DW +: DW] = pat(r, bb * OL + i);
        chk($sformatf("beat%0d", beats), {out_last, busy, out_data}, {bb == OB - 1, 1'b1, exp});
      end else if (started) begin
        nvec++; nerr++;
        $display("FAIL no_gap: out_valid=0 expected 1 after %0d beats", beats);
      end
      if (inject_at >= 0 && !injected && beats == inject_at) begin
        injected = 1;
        load_res(1);
        res_valid = 1'b1;
      end
`ifndef IO_STAGER_DBUF_EN
      if (injected && res_valid) begin
        hold++;
        if (hold > 6) res_valid = 1'b0;
      end
`endif
      out_ready = toggle ? cyc[0] : 1'b1;
      if (out_valid && out_ready) begin
        if (out_last) lasts++;
        beats++;
      end
      if (beats == total || beats == stop_at) break;
    end
    if (stop_at < 0) begin
      chk("beats_total", 64'(beats), 64'(total));
      @(negedge clk);
      out_ready = 1'b0;
      chk("idle_after", {out_valid, busy}, 64'd0);
      chk("ack_count", 64'(acks), 64'(nres));
      chk("last_count", 64'(lasts), 64'(nres));
    end
  endtask

  initial begin
    for (int j = 0; j < XI; j++) xm[j] = '0;
    for (int j = 0; j < WW; j++) wm[j] = '0;
    tbl[0] = '{1'b1, 1'b1,   0, 32'h87654321, 8'hFF, 1'b1,    0, 4'h1, 1'b1,    7, 4'h8};
    tbl[1] = '{1'b1, 1'b0, 703, 32'hFFFFFFFF, 8'hFF, 1'b0, 5624, 4'hF, 1'b0, 5623, 4'h0};
    tbl[2] = '{1'b1, 1'b1,   3, 32'h99999999, 8'hA5, 1'b1,   24, 4'h9, 1'b1,   25, 4'h0};
    tbl[3] = '{1'b1, 1'b1,  96, 32'hFFFFFFFF, 8'hFF, 1'b1,    0, 4'h1, 1'b1,  767, 4'h0};
    tbl[4] = '{1'b1, 1'b0,   0, 32'h12345678, 8'h0F, 1'b0,    0, 4'h8, 1'b0,    4, 4'h0};
    tbl[5] = '{1'b1, 1'b1,  95, 32'hAAAAAAAA, 8'h80, 1'b1,  767, 4'hA, 1'b1,  766, 4'h0};
    tbl[6] = '{1'b0, 1'b1,   0, 32'h00000000, 8'hFF, 1'b1,    0, 4'h1, 1'b1,    7, 4'h8};
    tbl[7] = '{1'b1, 1'b0,   3, 32'h11111111, 8'hFF, 1'b0,   24, 4'h1, 1'b1,   24, 4'h9};

    repeat (2) @(negedge clk);
    chk("rst_x", 64'(|x_out), 64'd0);
    chk("rst_w", 64'(|w_out), 64'd0);
    chk("rst_ser", {res_ack, out_valid, out_last, busy, out_data}, 64'd0);
    rst = 1'b1;

    for (int k = 0; k < 8; k++) begin
      apply_write(tbl[k]);
      chk($sformatf("v%0d_c0", k),
          tbl[k].c0x ? x_out[tbl[k].c0w*DW +: DW] : w_out[tbl[k].c0w*DW +: DW], tbl[k].c0e);
      chk($sformatf("v%0d_c1", k),
          tbl[k].c1x ? x_out[tbl[k].c1w*DW +: DW] : w_out[tbl[k].c1w*DW +: DW], tbl[k].c1e);
      check_image($sformatf("v%0d_image", k));
    end

    stream(1'b0, -1, -1);   // no backpressure
    stream(1'b1, 20, -1);   // toggled ready, second result mid-stream
    stream(1'b0, 10, -1);   // back-to-back (rejected without double buffering)

    stream(1'b0, -1, 50);   // reset mid-stream
    #1 rst = 1'b0;
    #1;
    chk("async_rst_ser", {res_ack, out_valid, out_last, busy}, 64'd0);
    chk("async_rst_x", 64'(|x_out), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    stream(1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
